// File: rtl/one_to_sixteen_deserializer_fsm.sv
// 1-to-16 serial receiver: samples LSB-first bits while ss is low and presents
// completed words on a valid/ack handshake, flagging aborted frames and overruns.
module one_to_sixteen_deserializer_fsm (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ss,
    input  logic        data_input,
    input  logic        data_ack,
    output logic [15:0] data_output,
    output logic        data_valid,
    output logic        frame_error,
    output logic        overrun,
    output logic [1:0]  y_Q
);

    localparam int unsigned WordW = 16;
    localparam int unsigned ShW   = WordW - 1;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECV   = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WordW-1:0]   shift_q, shift_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WordW-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    // State and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, shift and handshake logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;

        if (data_ack && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (!ss) begin
                    shift_d = {data_input, ShW'(0)};
                    cnt_d   = CntW'(1);
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (ss) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    shift_d = {data_input, shift_q[WordW-1:1]};
                    cnt_d   = cnt_q + CntW'(1);
                    // 16th bit: an ack on this same edge frees the slot, so no overrun
                    if (cnt_q == CntW'(WordW - 1)) begin
                        dout_d  = shift_d;
                        valid_d = 1'b1;
                        if (valid_q && !data_ack) begin
                            ovr_d = 1'b1;
                        end
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (ss) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_output = dout_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;
    assign y_Q         = state_q;

endmodule

// File: tb/tb_one_to_sixteen_deserializer_fsm.sv
// Bench for the 1-to-16 deserializer: frame table plus hand-written corner sequences,
// with completed words checked against a queue of expected words.
module tb_one_to_sixteen_deserializer_fsm;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ss = 1'b1;
    logic        data_input = 1'b0;
    logic        data_ack = 1'b0;
    logic [15:0] data_output;
    logic        data_valid;
    logic        frame_error;
    logic        overrun;
    logic [1:0]  y_Q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [1:0]  prev_y = 2'b00;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FLUSH = 2'b10;

    one_to_sixteen_deserializer_fsm dut (
        .clock       (clock),
        .resetn      (resetn),
        .ss          (ss),
        .data_input  (data_input),
        .data_ack    (data_ack),
        .data_output (data_output),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .overrun     (overrun),
        .y_Q         (y_Q)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word completion is the entry into FLUSH; each one must match the next queued word
    always @(negedge clock) begin
        if (resetn && y_Q == S_FLUSH && prev_y != S_FLUSH) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", data_output, 16'hxxxx);
            end else begin
                check("sb_word", data_output, exp_q.pop_front());
            end
        end
        prev_y = y_Q;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] word;
        logic        ack_done;
        logic        ack_gap;
        logic        exp_valid;
        logic        exp_ovr;
        logic        exp_valid_end;
    } vec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; ss = 1'b1; data_input = 1'b0; data_ack = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic send_frame(input logic [15:0] w, input logic ack_done);
        exp_q.push_back(w);
        for (int i = 0; i < 16; i++) begin
            ss = 1'b0;
            data_input = w[i];
            data_ack = (i == 15) ? ack_done : 1'b0;
            step();
        end
        ss = 1'b1; data_input = 1'b0; data_ack = 1'b0;
    endtask

    task automatic gap(input logic ack);
        ss = 1'b1;
        data_ack = ack;
        step();
        data_ack = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        do_reset();
        check("rst_y", 16'(y_Q), 16'(S_IDLE));
        check("rst_dout", data_output, 16'h0000);
        check("rst_valid", 16'(data_valid), 16'd0);
        check("rst_ferr", 16'(frame_error), 16'd0);
        check("rst_ovr", 16'(overrun), 16'd0);

        // Abort after 7 bits
        for (int i = 0; i < 7; i++) begin
            ss = 1'b0; data_input = 1'b1; step();
        end
        ss = 1'b1; data_input = 1'b0;
        step();
        check("abort_ferr", 16'(frame_error), 16'd1);
        check("abort_y", 16'(y_Q), 16'(S_IDLE));
        check("abort_valid", 16'(data_valid), 16'd0);
        check("abort_dout", data_output, 16'h0000);
        step();
        check("abort_ferr_clr", 16'(frame_error), 16'd0);

        // Back-to-back frames with minimum gap
        foreach (vecs[i]) begin
            send_frame(vecs[i].word, vecs[i].ack_done);
            check($sformatf("vec%0d_y", i), 16'(y_Q), 16'(S_FLUSH));
            check($sformatf("vec%0d_dout", i), data_output, vecs[i].word);
            check($sformatf("vec%0d_valid", i), 16'(data_valid), 16'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovr", i), 16'(overrun), 16'(vecs[i].exp_ovr));
            gap(vecs[i].ack_gap);
            check($sformatf("vec%0d_y_end", i), 16'(y_Q), 16'(S_IDLE));
            check($sformatf("vec%0d_valid_end", i), 16'(data_valid), 16'(vecs[i].exp_valid_end));
            check($sformatf("vec%0d_ovr_end", i), 16'(overrun), 16'(vecs[i].exp_ovr));
        end

        // Reset mid-frame after 9 bits
        for (int i = 0; i < 9; i++) begin
            ss = 1'b0; data_input = 1'b1; step();
        end
        resetn = 1'b0;
        #1;
        check("mrst_y", 16'(y_Q), 16'(S_IDLE));
        check("mrst_dout", data_output, 16'h0000);
        check("mrst_valid", 16'(data_valid), 16'd0);
        check("mrst_ovr", 16'(overrun), 16'd0);
        check("mrst_ferr", 16'(frame_error), 16'd0);
        ss = 1'b1; data_input = 1'b0;
        step();
        resetn = 1'b1;
        step();
        check("mrst_idle_wait", 16'(y_Q), 16'(S_IDLE));
        send_frame(16'h00FF, 1'b0);
        check("mrst_dout2", data_output, 16'h00FF);
        check("mrst_valid2", 16'(data_valid), 16'd1);
        gap(1'b0);

        // Overrun is sticky across a later ack
        do_reset();
        send_frame(16'h1234, 1'b0);
        gap(1'b0);
        send_frame(16'hBEEF, 1'b0);
        check("ovr_dout", data_output, 16'hBEEF);
        check("ovr_valid", 16'(data_valid), 16'd1);
        check("ovr_set", 16'(overrun), 16'd1);
        gap(1'b1);
        check("ovr_ack_valid", 16'(data_valid), 16'd0);
        check("ovr_sticky", 16'(overrun), 16'd1);
        gap(1'b1);
        check("ovr_idle_ack", 16'(data_valid), 16'd0);

        // ss held low for 32 cycles yields one word
        do_reset();
        exp_q.push_back(16'hFFFF);
        for (int i = 0; i < 32; i++) begin
            ss = 1'b0; data_input = (i < 16) ? 1'b1 : 1'b0; step();
            if (i == 20) check("hold_y_mid", 16'(y_Q), 16'(S_FLUSH));
        end
        check("hold_y", 16'(y_Q), 16'(S_FLUSH));
        check("hold_dout", data_output, 16'hFFFF);
        check("hold_ovr", 16'(overrun), 16'd0);
        ss = 1'b1; data_input = 1'b0;
        step();
        check("hold_release_y", 16'(y_Q), 16'(S_IDLE));

        step();
        check("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
